// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: grants core (C) or debug/loader (D) port, runs a
// WAIT-cycle access from latched request fields, then pulses the owner's done.
module mem_port_arbiter #(
  parameter int AW   = 8,
  parameter int DW   = 16,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          gnt_c,
  output logic          gnt_d,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic [1:0]    state_dbg
);

  // Handshake: a requester raises *_req with stable we/addr/wdata and keeps it
  // high until its one-cycle *_done; fields are latched at grant, so later
  // changes (or dropping req) do not affect the access in flight.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT - 1);

  state_t        state;
  state_t        state_nx;
  logic          owner;      // 0 = core, 1 = debug
  logic          last;       // owner of the most recently completed access
  logic [3:0]    cnt;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          grant;
  logic          grant_d;
  logic          acc_end;

  // Arbitration on ties favours the port that did not finish last.
  always_comb begin
    grant   = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (c_req && d_req) begin
        grant   = 1'b1;
        grant_d = ~last;
      end else if (c_req) begin
        grant   = 1'b1;
        grant_d = 1'b0;
      end else if (d_req) begin
        grant   = 1'b1;
        grant_d = 1'b1;
      end
    end
  end

  assign acc_end = (state == ACC) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = ACC;
      ACC:     if (cnt == 4'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= 1'b0;
      last      <= 1'b1;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      c_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      if (grant) begin
        owner     <= grant_d;
        cnt       <= CNT_LOAD;
        lat_we    <= grant_d ? d_we : c_we;
        lat_addr  <= grant_d ? d_addr : c_addr;
        lat_wdata <= grant_d ? d_wdata : c_wdata;
      end else if (state == ACC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Read data is only valid by the last access cycle.
      if (acc_end && !lat_we) begin
        if (owner) begin
          d_rdata <= m_rdata;
        end else begin
          c_rdata <= m_rdata;
        end
      end
      if (state == RESP) begin
        last <= owner;
      end
    end
  end

  always_comb begin
    m_en      = (state == ACC);
    m_we      = (state == ACC) && lat_we;
    m_addr    = (state == ACC) ? lat_addr : '0;
    m_wdata   = (state == ACC) ? lat_wdata : '0;
    gnt_c     = ((state == ACC) || (state == RESP)) && !owner;
    gnt_d     = ((state == ACC) || (state == RESP)) && owner;
    c_done    = (state == RESP) && !owner;
    d_done    = (state == RESP) && owner;
    state_dbg = state;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed and randomized transfers against a
// shadow-memory model with per-cycle timing expectations.
module tb_mem_port_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int WAIT = 2;

  logic          clk;
  logic          rst;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata, c_rdata, d_rdata;
  logic          c_done, d_done, gnt_c, gnt_d, m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [1:0]    state_dbg;

  mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_done(c_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .gnt_c(gnt_c), .gnt_d(gnt_d),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: unwritten locations return a fixed pattern of their address
  function automatic logic [DW-1:0] base(input logic [AW-1:0] a);
    return (a == 8'h10) ? 16'hBEEF : {a, ~a};
  endfunction

  logic [DW-1:0] mem [256];
  bit            wr_ok [256];
  always @(posedge clk) begin
    if (m_en && m_we) begin
      mem[m_addr]   <= m_wdata;
      wr_ok[m_addr] <= 1'b1;
    end
  end
  assign m_rdata = wr_ok[m_addr] ? mem[m_addr] : base(m_addr);

  // reference model state
  logic [DW-1:0] sh [logic [AW-1:0]];
  logic [DW-1:0] exp_rd [2];
  bit            exp_last;
  int            total = 0;
  int            bad = 0;

  function automatic logic [DW-1:0] exp_mem(input logic [AW-1:0] a);
    return sh.exists(a) ? sh[a] : base(a);
  endfunction

  // per-port drive values, index 0 = core, 1 = debug
  bit            req [2];
  bit            p_we [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wd [2];

  task automatic apply();
    c_req = req[0]; c_we = p_we[0]; c_addr = p_addr[0]; c_wdata = p_wd[0];
    d_req = req[1]; d_we = p_we[1]; d_addr = p_addr[1]; d_wdata = p_wd[1];
  endtask

  task automatic rand_op(input bit p);
    p_we[p]   = 1'($urandom_range(0, 1));
    p_addr[p] = 8'($urandom_range(0, 63));
    p_wd[p]   = 16'($urandom);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_c_done"}, c_done, 0);
    check({pfx, "_d_done"}, d_done, 0);
    check({pfx, "_gnt_c"}, gnt_c, 0);
    check({pfx, "_gnt_d"}, gnt_d, 0);
    check({pfx, "_m_en"}, m_en, 0);
    check({pfx, "_m_we"}, m_we, 0);
    check({pfx, "_m_addr"}, m_addr, 0);
    check({pfx, "_m_wdata"}, m_wdata, 0);
    check({pfx, "_c_rdata"}, c_rdata, 0);
    check({pfx, "_d_rdata"}, d_rdata, 0);
  endtask

  // driver: one isolated transfer on port p, checked cycle by cycle
  task automatic single(input bit p, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input bit scramble, input bit drop);
    @(negedge clk);
    p_we[p] = we; p_addr[p] = a; p_wd[p] = wd; req[p] = 1'b1;
    apply();
    for (int i = 1; i <= WAIT; i++) begin
      @(negedge clk);
      check("acc_en", m_en, 1);
      check("acc_we", m_we, we);
      check("acc_addr", m_addr, a);
      check("acc_wdata", m_wdata, wd);
      check("acc_gnt_own", p ? gnt_d : gnt_c, 1);
      check("acc_gnt_oth", p ? gnt_c : gnt_d, 0);
      check("acc_no_done", c_done | d_done, 0);
      if (i == 1 && scramble) begin
        p_addr[p] = 8'($urandom_range(64, 255));
        p_wd[p]   = ~wd;
        apply();
      end
      if (i == 1 && drop) begin
        req[p] = 1'b0;
        apply();
      end
    end
    @(negedge clk);
    check("resp_done_own", p ? d_done : c_done, 1);
    check("resp_done_oth", p ? c_done : d_done, 0);
    check("resp_gnt_own", p ? gnt_d : gnt_c, 1);
    check("resp_m_en", m_en, 0);
    if (!we) exp_rd[p] = exp_mem(a);
    else sh[a] = wd;
    check("resp_c_rdata", c_rdata, exp_rd[0]);
    check("resp_d_rdata", d_rdata, exp_rd[1]);
    req[p] = 1'b0;
    apply();
    exp_last = p;
    @(negedge clk);
    check("idle_done", c_done | d_done, 0);
    check("idle_gnt", gnt_c | gnt_d, 0);
    check("idle_m_en", m_en, 0);
  endtask

  // driver: both ports request continuously; service must alternate
  task automatic contend(input int n, input bit rel);
    bit exp_port;
    int since;
    int exp_gap;
    @(negedge clk);
    if (rel) rst = 1'b1;
    req[0] = 1'b1; req[1] = 1'b1;
    apply();
    exp_port = ~exp_last;
    for (int t = 0; t < n; t++) begin
      exp_gap = (t == 0) ? WAIT + 1 : WAIT + 2;
      since = 0;
      do begin
        @(negedge clk);
        since++;
        check("cont_excl", gnt_c & gnt_d, 0);
        if (m_en) begin
          check("cont_gnt", exp_port ? gnt_d : gnt_c, 1);
          check("cont_addr", m_addr, p_addr[exp_port]);
          check("cont_we", m_we, p_we[exp_port]);
        end
      end while (!(c_done || d_done) && since < WAIT + 4);
      check("cont_gap", since, exp_gap);
      if (!(c_done || d_done)) return;
      check("cont_done_port", d_done, exp_port);
      check("cont_done_one", c_done & d_done, 0);
      if (!p_we[exp_port]) exp_rd[exp_port] = exp_mem(p_addr[exp_port]);
      else sh[p_addr[exp_port]] = p_wd[exp_port];
      check("cont_c_rdata", c_rdata, exp_rd[0]);
      check("cont_d_rdata", d_rdata, exp_rd[1]);
      exp_last = exp_port;
      rand_op(exp_port);
      apply();
      exp_port = ~exp_port;
    end
    req[0] = 1'b0; req[1] = 1'b0;
    apply();
    repeat (2) @(negedge clk);
    check("cont_end_idle", m_en | gnt_c | gnt_d, 0);
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wd[i] = '0; exp_rd[i] = '0;
    end
    apply();
    exp_last = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // core read, debug write, core read-back of the written word
    single(1'b0, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0);
    check("beef", c_rdata, 16'hBEEF);
    single(1'b1, 1'b1, 8'h3F, 16'h1234, 1'b0, 1'b0);
    single(1'b0, 1'b0, 8'h3F, 16'h5555, 1'b0, 1'b0);
    check("readback", c_rdata, 16'h1234);

    // inputs changed during access, request dropped mid-access
    single(1'b0, 1'b1, 8'h22, 16'hA5C3, 1'b1, 1'b0);
    single(1'b0, 1'b0, 8'h22, 16'h0F0F, 1'b1, 1'b1);
    single(1'b1, 1'b0, 8'h22, 16'h0000, 1'b0, 1'b1);

    // randomized isolated transfers
    for (int k = 0; k < 12; k++) begin
      bit p;
      p = 1'($urandom_range(0, 1));
      rand_op(p);
      single(p, p_we[p], p_addr[p], p_wd[p], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // first tie after reset goes to core, then strict alternation
    @(negedge clk);
    rst = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_last = 1'b1;
    @(negedge clk);
    rand_op(1'b0); rand_op(1'b1);
    apply();
    contend(6, 1'b1);

    rand_op(1'b0); rand_op(1'b1);
    contend(8, 1'b0);

    // reset in the middle of an access
    @(negedge clk);
    req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 8'($urandom_range(0, 63));
    apply();
    @(negedge clk);
    check("mid_pre_en", m_en, 1);
    req[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 8'($urandom_range(0, 63));
    apply();
    #2 rst = 1'b0;
    #1 check_all_zero("mid_rst");
    repeat (2) begin
      @(negedge clk);
      check("mid_no_done", c_done | d_done, 0);
    end
    exp_rd[0] = '0; exp_rd[1] = '0; exp_last = 1'b1;
    contend(4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared memory port of the multicycle core. It grants the memory to either the core controller (instruction fetch, LW/SW, PUSH/POP) or the debug/loader port, drives the memory for a programmable number of wait cycles, and returns read data with a one-cycle done pulse. The core controller holds its state while its request is pending. Arbitration is round-robin on ties.

## Interface
- AW, 8, address width
- DW, 16, data width
- WAIT, 2, memory access cycles per transfer; legal range 1..15
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- c_req  in  1  core request, held high until c_done
- c_we  in  1  core write (1) / read (0), valid with c_req
- c_addr  in  AW  core address
- c_wdata  in  DW  core write data
- c_rdata  out  DW  core read data, valid in c_done cycle, held until next core read completes
- c_done  out  1  one-cycle completion pulse to core
- d_req, d_we, d_addr, d_wdata, d_rdata, d_done: same widths and rules as the c_ group, for the debug/loader port
- gnt_c  out  1  core owns memory (ACC and RESP states)
- gnt_d  out  1  debug port owns memory
- m_en  out  1  memory enable
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid by the last ACC cycle

## Operation
- States: IDLE, ACC, RESP. Registers: owner (C/D), last owner `last`, 4-bit wait counter, latched we/addr/wdata, c_rdata and d_rdata holding registers.
- IDLE: arbitrate on sampled requests.
  - Only c_req: grant C. Only d_req: grant D.
  - Both: grant the port that is not `last`.
  - On grant: latch the owner's we/addr/wdata, set owner, load counter with WAIT-1, go to ACC.
  - No request: stay in IDLE.
- ACC:
  - m_en=1; m_we=latched we; m_addr/m_wdata from latches.
  - Counter decrements each cycle. At counter==0 go to RESP.
  - On that edge, if the access is a read, capture m_rdata into the owner's rdata register.
  - Writes repeat the same address/data every ACC cycle; this is idempotent by design.
- RESP:
  - Owner's done=1 for exactly one cycle; set last=owner; go to IDLE unconditionally.
  - The finished requester's req is still high in RESP and is not sampled there.
- gnt_c/gnt_d are high in ACC and RESP for the respective owner, low in IDLE. They are never both high.
- The non-owner's rdata register is never modified. A write does not change the owner's rdata.
- Request dropped mid-access: the access still completes and done still pulses. There is no abort.
- Request inputs changing address/data during ACC have no effect, because the latched values are used.
- Request still high in the IDLE cycle after RESP: treated as a new request, and the requester is responsible for dropping req after done.
- WAIT outside 1..15 is a configuration error. Behaviour is not defined.

## Timing
- Reset (async, rst low): state=IDLE, last=D so the core wins the first tie, counter=0. Reset values of outputs:
  - c_done, d_done, gnt_c, gnt_d, m_en, m_we = 0.
  - m_addr, m_wdata, c_rdata, d_rdata = 0.
- Reset mid-access: the access is aborted immediately, no done is issued, and m_en drops asynchronously.
- Request sampled high in IDLE at edge k:
  - ACC for cycles k+1..k+WAIT.
  - RESP (done) in cycle k+WAIT+1.
  - IDLE in cycle k+WAIT+2.
- Occupancy is WAIT+2 cycles per transfer. Back-to-back accesses to alternating ports under continuous contention are each WAIT+2 cycles apart.
- All outputs are registered or decoded from state only. There is no combinational path from any *_req to any output.

## Test plan
- Core read alone, WAIT=2, c_addr=0x10, memory returns 0xBEEF:
  - m_en high exactly 2 cycles.
  - c_done pulses 3 cycles after the request edge with c_rdata=0xBEEF.
  - d_done stays 0.
- Debug write, d_addr=0x3F, d_wdata=0x1234: m_we=1 with m_addr=0x3F and m_wdata=0x1234 for WAIT cycles, one d_done pulse, d_rdata unchanged.
- Simultaneous c_req and d_req first after reset:
  - C is served first, then D.
  - With both held continuously, grants alternate C,D,C,D, and each done is WAIT+2 cycles apart.
- Change c_addr/c_wdata during ACC: memory still sees the values latched at grant.
- Drop c_req after one ACC cycle: access completes and c_done still pulses once.
- Assert rst in the middle of ACC:
  - All outputs 0 immediately and no done is issued.
  - After release, a pending d_req and c_req are served C first.
